// File: rtl/usb3_tx_hdr_arb.sv
// usb3_tx_hdr_arb
//   Round-robin arbiter that offers one of three USB3 header descriptors to
//   the link TX path.
//   - Grants happen only while the link is in U0.
//   - The offered descriptor is held stable until the link accepts it, or
//     until the offer is withdrawn.
//   - After an accepted (or timed-out) offer, one GAP cycle follows before
//     the next grant.
//
// Optional feature: define USB3_TXARB_TIMEOUT_EN to enable a link-ack
// timeout of TIMEOUT_CYC cycles. Without it, BUSY waits indefinitely and
// timeout is tied low.
//
// Ports
//   clk                     single clock
//   reset_n                 asynchronous active-low reset
//   link_u0                 link in U0; grants only while high
//   req[2:0]                level requests {c,b,a}, held until matching ack
//   desc_a/desc_b/desc_c    36-bit header descriptors
//   ack[2:0]                one-cycle grant-complete pulse per requester
//   tp_valid / tp_desc      descriptor offered to link TX
//   tp_ack                  link accepted tp_desc (only meaningful in BUSY)
//   abort                   one-cycle pulse: offer withdrawn, link left U0
//   timeout                 one-cycle pulse: link-ack timeout expired
module usb3_tx_hdr_arb #(
    parameter int unsigned TIMEOUT_CYC = 255,
    localparam int unsigned DESC_W     = 36,
    localparam int unsigned NREQ       = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              link_u0,
    input  logic [NREQ-1:0]   req,
    input  logic [DESC_W-1:0] desc_a,
    input  logic [DESC_W-1:0] desc_b,
    input  logic [DESC_W-1:0] desc_c,
    output logic [NREQ-1:0]   ack,
    output logic              tp_valid,
    output logic [DESC_W-1:0] tp_desc,
    input  logic              tp_ack,
    output logic              abort,
    output logic              timeout
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        rr_q, rr_d;
    logic [1:0]        g_q, g_d;
    logic              tp_valid_q, tp_valid_d;
    logic [DESC_W-1:0] tp_desc_q, tp_desc_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic              abort_q, abort_d;

    logic [1:0]        cand1_c, cand2_c;
    logic [1:0]        sel_idx_c;
    logic              sel_vld_c;
    logic [DESC_W-1:0] sel_desc_c;

`ifdef USB3_TXARB_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);
    logic [7:0] cnt_q, cnt_d;
    logic       timeout_q, timeout_d;
`else
    // Parameter is only meaningful with the timeout feature compiled in.
    localparam int unsigned unused_timeout_cyc = TIMEOUT_CYC;
`endif

    // Index increment modulo 3.
    function automatic logic [1:0] rr_next(input logic [1:0] i);
        return (i == 2'd2) ? 2'd0 : 2'(i + 2'd1);
    endfunction

    // Round-robin pick: first active request at or after the pointer.
    always_comb begin
        cand1_c   = rr_next(rr_q);
        cand2_c   = rr_next(cand1_c);
        sel_vld_c = |req;
        sel_idx_c = cand2_c;
        if (req[rr_q]) begin
            sel_idx_c = rr_q;
        end else if (req[cand1_c]) begin
            sel_idx_c = cand1_c;
        end
        case (sel_idx_c)
            2'd0:    sel_desc_c = desc_a;
            2'd1:    sel_desc_c = desc_b;
            default: sel_desc_c = desc_c;
        endcase
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        g_d        = g_q;
        tp_valid_d = tp_valid_q;
        tp_desc_d  = tp_desc_q;
        ack_d      = '0;
        abort_d    = 1'b0;
`ifdef USB3_TXARB_TIMEOUT_EN
        cnt_d      = cnt_q;
        timeout_d  = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (link_u0 && sel_vld_c) begin
                    state_d    = ST_BUSY;
                    g_d        = sel_idx_c;
                    tp_valid_d = 1'b1;
                    tp_desc_d  = sel_desc_c;
`ifdef USB3_TXARB_TIMEOUT_EN
                    cnt_d      = '0;
`endif
                end
            end
            ST_BUSY: begin
                // Link loss beats acceptance; acceptance beats timeout.
                if (!link_u0) begin
                    state_d    = ST_IDLE;
                    tp_valid_d = 1'b0;
                    abort_d    = 1'b1;
                end else if (tp_ack) begin
                    state_d    = ST_GAP;
                    tp_valid_d = 1'b0;
                    ack_d      = NREQ'(3'b001 << g_q);
                    rr_d       = rr_next(g_q);
`ifdef USB3_TXARB_TIMEOUT_EN
                end else if (cnt_q == TO_LAST) begin
                    state_d    = ST_GAP;
                    tp_valid_d = 1'b0;
                    timeout_d  = 1'b1;
                    rr_d       = rr_next(g_q);
                end else begin
                    cnt_d      = cnt_q + 8'd1;
`endif
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d    = ST_IDLE;
                tp_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            rr_q       <= 2'd0;
            g_q        <= 2'd0;
            tp_valid_q <= 1'b0;
            tp_desc_q  <= '0;
            ack_q      <= '0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            g_q        <= g_d;
            tp_valid_q <= tp_valid_d;
            tp_desc_q  <= tp_desc_d;
            ack_q      <= ack_d;
            abort_q    <= abort_d;
        end
    end

`ifdef USB3_TXARB_TIMEOUT_EN
    // Ack-timeout counter and pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign ack      = ack_q;
    assign tp_valid = tp_valid_q;
    assign tp_desc  = tp_desc_q;
    assign abort    = abort_q;

endmodule

// File: tb/tb_usb3_tx_hdr_arb.sv
// tb_usb3_tx_hdr_arb: directed scenarios plus randomized traffic, checked
// against a transaction-level model of the arbiter.
module tb_usb3_tx_hdr_arb;

    localparam int unsigned TB_TO = 4;
    localparam logic [35:0] DA = 36'hA_AAAA_0001;
    localparam logic [35:0] DB = 36'hB_BBBB_0002;
    localparam logic [35:0] DC = 36'hC_CCCC_0003;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;
    logic        link_u0 = 1'b1;
    logic        tp_ack  = 1'b0;
    logic [2:0]  req     = 3'b000;
    logic [35:0] d [3];

    logic [2:0]  ack;
    logic        tp_valid;
    logic [35:0] tp_desc;
    logic        abort;
    logic        timeout;

    int n_checks = 0;
    int n_errors = 0;

    usb3_tx_hdr_arb #(.TIMEOUT_CYC(TB_TO)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .link_u0 (link_u0),
        .req     (req),
        .desc_a  (d[0]),
        .desc_b  (d[1]),
        .desc_c  (d[2]),
        .ack     (ack),
        .tp_valid(tp_valid),
        .tp_desc (tp_desc),
        .tp_ack  (tp_ack),
        .abort   (abort),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // An offer is either pending (m_valid) or not; after an accepted or
    // timed-out offer, one idle turn (m_gap) must pass before the next grant.
    logic        m_valid;
    logic        m_gap;
    int          m_owner;
    int          m_rr;
    int          m_age;
    logic [35:0] m_desc;
    logic [2:0]  m_ack;
    logic        m_abort;
    logic        m_timeout;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_valid = 1'b0; m_gap = 1'b0; m_owner = 0; m_rr = 0; m_age = 0;
            m_desc = '0; m_ack = '0; m_abort = 1'b0; m_timeout = 1'b0;
        end else begin
            m_ack = '0; m_abort = 1'b0; m_timeout = 1'b0;
            if (m_valid) begin
                if (!link_u0) begin
                    m_valid = 1'b0;
                    m_abort = 1'b1;
                end else if (tp_ack) begin
                    m_valid = 1'b0;
                    m_ack   = 3'(1 << m_owner);
                    m_rr    = (m_owner + 1) % 3;
                    m_gap   = 1'b1;
`ifdef USB3_TXARB_TIMEOUT_EN
                end else if (m_age + 1 >= int'(TB_TO)) begin
                    m_valid   = 1'b0;
                    m_timeout = 1'b1;
                    m_rr      = (m_owner + 1) % 3;
                    m_gap     = 1'b1;
`endif
                end else begin
                    m_age++;
                end
            end else if (m_gap) begin
                m_gap = 1'b0;
            end else if (link_u0 && req != 3'b000) begin
                for (int k = 2; k >= 0; k--)
                    if (req[(m_rr + k) % 3]) m_owner = (m_rr + k) % 3;
                m_desc  = d[m_owner];
                m_valid = 1'b1;
                m_age   = 0;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        #2;
        chk("cmp_tp_valid", 64'(tp_valid), 64'(m_valid));
        chk("cmp_ack", 64'(ack), 64'(m_ack));
        chk("cmp_abort", 64'(abort), 64'(m_abort));
        chk("cmp_timeout", 64'(timeout), 64'(m_timeout));
        if (m_valid) chk("cmp_tp_desc", 64'(tp_desc), 64'(m_desc));
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [35:0] rnd36();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[35:0];
    endfunction

    task automatic rand_drive();
        for (int i = 0; i < 3; i++) begin
            if (ack[i]) begin
                if ($urandom_range(0, 3) != 0) req[i] = 1'b0;
            end else if (!req[i]) begin
                if ($urandom_range(0, 5) == 0) begin
                    req[i] = 1'b1;
                    d[i]   = rnd36();
                end
            end else if ($urandom_range(0, 15) == 0) begin
                d[i] = rnd36();
            end
        end
        tp_ack = ($urandom_range(0, 2) == 0);
        if (link_u0) begin
            if ($urandom_range(0, 49) == 0) link_u0 = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
            link_u0 = 1'b1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          grants;
        int          low;
        int          busy;
        logic        prev_valid;
        logic [35:0] order [4];

        d[0] = '0; d[1] = '0; d[2] = '0;
        repeat (3) step();
        chk("rst_tp_valid", 64'(tp_valid), 64'd0);
        chk("rst_tp_desc", 64'(tp_desc), 64'd0);
        chk("rst_ack", 64'(ack), 64'd0);
        chk("rst_abort", 64'(abort), 64'd0);
        chk("rst_timeout", 64'(timeout), 64'd0);
        reset_n = 1'b1;
        step();

        // Single request from a, accepted two cycles after the offer.
        d[0] = 36'h0_1234_5678;
        req  = 3'b001;
        step();
        chk("t26_valid", 64'(tp_valid), 64'd1);
        chk("t26_desc", 64'(tp_desc), 64'h0_1234_5678);
        step();
        step();
        chk("t26_still_valid", 64'(tp_valid), 64'd1);
        tp_ack = 1'b1;
        step();
        chk("t26_ack", 64'(ack), 64'b001);
        chk("t26_valid_drop", 64'(tp_valid), 64'd0);
        tp_ack = 1'b0;
        req    = 3'b000;
        step();
        chk("t26_ack_once", 64'(ack), 64'd0);
        // Pointer now at b.
        d[0] = DA; d[1] = DB; d[2] = DC;
        req  = 3'b111;
        step();
        chk("t26_rr_b", 64'(tp_desc), 64'(DB));

        // Reset in the middle of an offer.
        step();
        #2;
        reset_n = 1'b0;
        #1;
        chk("t30_valid_async", 64'(tp_valid), 64'd0);
        chk("t30_no_ack", 64'(ack), 64'd0);
        chk("t30_no_abort", 64'(abort), 64'd0);
        step();
        reset_n = 1'b1;

        // All three requesting, immediate accept: order a,b,c,a.
        grants = 0; low = 0; prev_valid = 1'b0;
        for (int cyc = 0; cyc < 40 && grants < 4; cyc++) begin
            step();
            if (tp_valid) begin
                if (!prev_valid) begin
                    order[grants] = tp_desc;
                    if (grants > 0) chk("t27_gap", 64'(low), 64'd2);
                    grants++;
                end
                low    = 0;
                tp_ack = 1'b1;
            end else begin
                low++;
                tp_ack = 1'b0;
            end
            prev_valid = tp_valid;
        end
        chk("t27_grants", 64'(grants), 64'd4);
        chk("t27_g0", 64'(order[0]), 64'(DA));
        chk("t27_g1", 64'(order[1]), 64'(DB));
        chk("t27_g2", 64'(order[2]), 64'(DC));
        chk("t27_g3", 64'(order[3]), 64'(DA));
        step();
        tp_ack = 1'b0;
        req    = 3'b000;
        repeat (3) step();

        // Link drops on the 3rd BUSY cycle together with tp_ack.
        req = 3'b010;
        step();
        chk("t28_b1", 64'(tp_valid), 64'd1);
        step();
        step();
        link_u0 = 1'b0;
        tp_ack  = 1'b1;
        step();
        chk("t28_abort", 64'(abort), 64'd1);
        chk("t28_no_ack", 64'(ack), 64'd0);
        chk("t28_valid_drop", 64'(tp_valid), 64'd0);
        tp_ack = 1'b0;
        busy = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (tp_valid || abort) busy++;
        end
        chk("t28_quiet_link_down", 64'(busy), 64'd0);
        // Pointer unchanged (still b): with all requesting, b is chosen.
        req     = 3'b111;
        link_u0 = 1'b1;
        step();
        chk("t28_regrant_valid", 64'(tp_valid), 64'd1);
        chk("t28_regrant_b", 64'(tp_desc), 64'(DB));
        tp_ack = 1'b1;
        step();
        chk("t28_ack_b", 64'(ack), 64'b010);
        tp_ack = 1'b0;
        req    = 3'b000;
        repeat (3) step();

        // Descriptor change during BUSY must not disturb the offer.
        d[0] = 36'h1_1111_1111;
        req  = 3'b001;
        step();
        chk("t31_desc", 64'(tp_desc), 64'h1_1111_1111);
        d[0] = 36'h2_2222_2222;
        step();
        step();
        chk("t31_hold", 64'(tp_desc), 64'h1_1111_1111);
        tp_ack = 1'b1;
        step();
        chk("t31_ack", 64'(ack), 64'b001);
        tp_ack = 1'b0;
        step();
        chk("t31_gap_no_grant", 64'(tp_valid), 64'd0);
        step();
        chk("t31_new_desc", 64'(tp_desc), 64'h2_2222_2222);
        tp_ack = 1'b1;
        step();
        tp_ack = 1'b0;
        req    = 3'b000;
        repeat (3) step();

`ifdef USB3_TXARB_TIMEOUT_EN
        // No acceptance from the link: timeout after TB_TO BUSY cycles.
        d[2] = 36'h3_3333_3333;
        req  = 3'b100;
        step();
        busy = 0;
        for (int i = 0; i < 20 && tp_valid; i++) begin
            busy++;
            step();
        end
        chk("to_busy_len", 64'(busy), 64'd4);
        chk("to_pulse", 64'(timeout), 64'd1);
        chk("to_no_ack", 64'(ack), 64'd0);
        step();
        step();
        chk("to_regrant_c", 64'(tp_desc), 64'h3_3333_3333);
        chk("to_regrant_valid", 64'(tp_valid), 64'd1);
        tp_ack = 1'b1;
        step();
        tp_ack = 1'b0;
        req    = 3'b000;
        repeat (3) step();
`else
        // No acceptance from the link: offer is held indefinitely.
        req = 3'b100;
        step();
        busy = 0;
        for (int i = 0; i < 300; i++) begin
            if (!tp_valid || timeout) busy++;
            step();
        end
        chk("noto_held", 64'(busy), 64'd0);
        tp_ack = 1'b1;
        step();
        chk("noto_ack_c", 64'(ack), 64'b100);
        tp_ack = 1'b0;
        req    = 3'b000;
        repeat (3) step();
`endif

        // Randomized traffic.
        for (int c = 0; c < 4000; c++) begin
            step();
            rand_drive();
        end
        link_u0 = 1'b1;
        tp_ack  = 1'b0;
        req     = 3'b000;
        repeat (5) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
